// File: rtl/adpll_lock_monitor.sv
// ADPLL lock monitor: windowed alpha-spread / lead-lag toggle qualification with lock FSM.
// Optional statistics (lol_count, alpha_lock) are built when LOCK_MON_STATS_EN is defined.
module adpll_lock_monitor #(
   parameter int unsigned WIN       = 16,
   parameter int unsigned TOL       = 2,
   parameter int unsigned MIN_TOG   = 4,
   parameter int unsigned GOOD_WINS = 2,
   parameter int unsigned ACQ_TO    = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        lead_lag,
   input  logic [6:0]  alpha,
   input  logic        clr,
   output logic        locked,
   output logic        lol_pulse,
   output logic        lol_sticky,
   output logic        acq_timeout,
   output logic        alpha_rail,
   output logic [1:0]  state,
   output logic [15:0] lol_count,
   output logic [6:0]  alpha_lock
);

   localparam int unsigned CW = (WIN > 1) ? $clog2(WIN) : 1;
   localparam int unsigned GW = $clog2(GOOD_WINS + 1);
   localparam int unsigned AW = $clog2(ACQ_TO + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACQUIRE = 2'd1,
      S_LOCKED  = 2'd2,
      S_LOST    = 2'd3
   } state_t;

   state_t          st_q, st_d;
   logic [CW-1:0]   win_cnt;
   logic [6:0]      amin_q, amax_q, amin_n, amax_n, spread;
   logic [7:0]      tog_q, tog_n;
   logic            all0_q, all127_q, all0_n, all127_n;
   logic            lead_lag_q, tog_hit;
   logic [GW-1:0]   good_q, good_d;
   logic [AW-1:0]   acq_q, acq_d;
   logic            first, last, active, win_end, railed, good;
   logic            lol_ev, to_set;

   // Window statistics including the sample presented this cycle
   always_comb begin
      active   = en && (st_q != S_IDLE);
      first    = (win_cnt == '0);
      last     = (win_cnt == CW'(WIN - 1));
      win_end  = active && last;
      tog_hit  = lead_lag ^ lead_lag_q;
      amin_n   = (first || (alpha < amin_q)) ? alpha : amin_q;
      amax_n   = (first || (alpha > amax_q)) ? alpha : amax_q;
      tog_n    = first ? 8'(tog_hit) :
                 (tog_q == 8'd255) ? tog_q : tog_q + 8'(tog_hit);
      all0_n   = (alpha == 7'd0)   && (first || all0_q);
      all127_n = (alpha == 7'd127) && (first || all127_q);
      spread   = amax_n - amin_n;
      railed   = all0_n || all127_n;
      good     = (32'(spread) <= TOL) && (32'(tog_n) >= MIN_TOG) && !railed;
   end

   // Next-state and event decode
   always_comb begin
      st_d   = st_q;
      good_d = good_q;
      acq_d  = acq_q;
      lol_ev = 1'b0;
      to_set = 1'b0;
      if (!en) begin
         st_d   = S_IDLE;
         good_d = '0;
         acq_d  = '0;
      end else begin
         case (st_q)
            S_IDLE: begin
               st_d   = S_ACQUIRE;
               good_d = '0;
               acq_d  = '0;
            end
            S_ACQUIRE: begin
               if (win_end) begin
                  if (32'(acq_q) < ACQ_TO) acq_d = acq_q + AW'(1);
                  if (32'(acq_q) + 32'd1 == ACQ_TO) to_set = 1'b1;
                  if (!good) begin
                     good_d = '0;
                  end else if (32'(good_q) + 32'd1 >= GOOD_WINS) begin
                     good_d = '0;
                     st_d   = S_LOCKED;
                  end else begin
                     good_d = good_q + GW'(1);
                  end
               end
            end
            S_LOCKED: begin
               if (win_end && !good) begin
                  st_d   = S_LOST;
                  lol_ev = 1'b1;
               end
            end
            default: begin
               if (win_end && good) begin
                  st_d   = S_ACQUIRE;
                  good_d = GW'(1);
                  acq_d  = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q        <= S_IDLE;
         win_cnt     <= '0;
         amin_q      <= '0;
         amax_q      <= '0;
         tog_q       <= '0;
         all0_q      <= 1'b0;
         all127_q    <= 1'b0;
         lead_lag_q  <= 1'b0;
         good_q      <= '0;
         acq_q       <= '0;
         locked      <= 1'b0;
         lol_pulse   <= 1'b0;
         lol_sticky  <= 1'b0;
         acq_timeout <= 1'b0;
         alpha_rail  <= 1'b0;
      end else begin
         st_q       <= st_d;
         good_q     <= good_d;
         acq_q      <= acq_d;
         lead_lag_q <= lead_lag;
         if (active) begin
            win_cnt  <= last ? '0 : win_cnt + CW'(1);
            amin_q   <= amin_n;
            amax_q   <= amax_n;
            tog_q    <= tog_n;
            all0_q   <= all0_n;
            all127_q <= all127_n;
         end else begin
            win_cnt <= '0;
            tog_q   <= '0;
         end
         locked    <= (st_d == S_LOCKED);
         lol_pulse <= lol_ev;
         if (lol_ev)      lol_sticky <= 1'b1;
         else if (clr)    lol_sticky <= 1'b0;
         if (to_set)      acq_timeout <= 1'b1;
         else if (clr)    acq_timeout <= 1'b0;
         if (win_end)     alpha_rail <= railed;
      end
   end

   assign state = st_q;

`ifdef LOCK_MON_STATS_EN
   logic [15:0] lol_cnt_q;
   logic [6:0]  alpha_lock_q;

   // Loss-of-lock counter and lock-entry alpha midpoint snapshot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lol_cnt_q    <= '0;
         alpha_lock_q <= '0;
      end else begin
         if (lol_ev) begin
            if (lol_cnt_q != 16'hffff) lol_cnt_q <= lol_cnt_q + 16'd1;
         end else if (clr) begin
            lol_cnt_q <= '0;
         end
         if (st_d == S_LOCKED && st_q != S_LOCKED)
            alpha_lock_q <= 7'((8'(amin_n) + 8'(amax_n)) >> 1);
      end
   end

   assign lol_count  = lol_cnt_q;
   assign alpha_lock = alpha_lock_q;
`else
   assign lol_count  = '0;
   assign alpha_lock = '0;
`endif

endmodule

// File: tb/tb_adpll_lock_monitor.sv
// Directed bench for adpll_lock_monitor (default parameters); stats expectations follow LOCK_MON_STATS_EN.
module tb_adpll_lock_monitor;

   logic        clk = 1'b0;
   logic        rst_n, en, lead_lag, clr;
   logic [6:0]  alpha;
   logic        locked, lol_pulse, lol_sticky, acq_timeout, alpha_rail;
   logic [1:0]  state;
   logic [15:0] lol_count;
   logic [6:0]  alpha_lock;

`ifdef LOCK_MON_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   int n_chk = 0;
   int n_err = 0;

   logic       tog_mode = 1'b1;
   logic       alt = 1'b0;
   logic [6:0] hi = 7'd64;
   logic [6:0] lo = 7'd63;

   adpll_lock_monitor dut (
      .clk(clk), .rst_n(rst_n), .en(en), .lead_lag(lead_lag), .alpha(alpha), .clr(clr),
      .locked(locked), .lol_pulse(lol_pulse), .lol_sticky(lol_sticky),
      .acq_timeout(acq_timeout), .alpha_rail(alpha_rail), .state(state),
      .lol_count(lol_count), .alpha_lock(alpha_lock)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present next stimulus at the falling edge, then pass one rising edge
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         if (tog_mode) lead_lag = ~lead_lag;
         alt   = ~alt;
         alpha = alt ? hi : lo;
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; lead_lag = 1'b0; clr = 1'b0; alpha = 7'd0;
      #1;
      check("rst_state", 32'(state), 0);
      check("rst_locked", 32'(locked), 0);
      check("rst_sticky", 32'(lol_sticky), 0);
      check("rst_lolcnt", 32'(lol_count), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Acquire and lock on a quiet alpha with toggling lead_lag
      en = 1'b1;
      cyc(1);  check("acq_state", 32'(state), 1);
      cyc(31); check("pre_lock", 32'(locked), 0);
      cyc(1);  check("lock_33", 32'(locked), 1);
      check("lock_state", 32'(state), 2);
      check("alpha_lock", 32'(alpha_lock), STATS * 63);

      // Alpha spread opens -> loss of lock at the following window end
      hi = 7'd70; lo = 7'd60;
      cyc(15); check("still_locked", 32'(state), 2);
      check("no_pulse_yet", 32'(lol_pulse), 0);
      cyc(1);  check("lol_pulse", 32'(lol_pulse), 1);
      check("lost_state", 32'(state), 3);
      check("lol_sticky", 32'(lol_sticky), 1);
      check("locked_drop", 32'(locked), 0);
      check("lol_count1", 32'(lol_count), STATS * 1);
      hi = 7'd64; lo = 7'd63;
      cyc(1);  check("pulse_1cyc", 32'(lol_pulse), 0);
      cyc(15); check("lost_to_acq", 32'(state), 1);
      cyc(15); check("reacq_wait", 32'(state), 1);
      cyc(1);  check("relock", 32'(state), 2);

      // clr coincident with the loss event: set wins, then clr alone clears
      hi = 7'd70; lo = 7'd60;
      cyc(15); check("sticky_held", 32'(lol_sticky), 1);
      clr = 1'b1;
      cyc(1);  check("clr_set_wins", 32'(lol_sticky), 1);
      check("lol_pulse2", 32'(lol_pulse), 1);
      check("lol_count2", 32'(lol_count), STATS * 2);
      cyc(1);  check("clr_sticky", 32'(lol_sticky), 0);
      check("clr_count", 32'(lol_count), 0);
      clr = 1'b0;

      // Restart via enable, relock, then a one-cycle enable drop
      hi = 7'd64; lo = 7'd63; en = 1'b0;
      cyc(1);  check("en_idle", 32'(state), 0);
      en = 1'b1;
      cyc(32); check("relock_pre", 32'(locked), 0);
      cyc(1);  check("relock_33", 32'(locked), 1);
      en = 1'b0;
      cyc(1);  check("drop_idle", 32'(state), 0);
      check("drop_unlock", 32'(locked), 0);
      check("drop_sticky", 32'(lol_sticky), 0);
      en = 1'b1;
      cyc(1);  check("drop_acq", 32'(state), 1);
      check("drop_pulse", 32'(lol_pulse), 0);

      // Railed alpha at 127 with constant lead_lag: rail flag and acquire timeout
      en = 1'b0; hi = 7'd127; lo = 7'd127; tog_mode = 1'b0;
      cyc(1);
      en = 1'b1;
      cyc(16);  check("rail_pre", 32'(alpha_rail), 0);
      cyc(1);   check("rail_set", 32'(alpha_rail), 1);
      cyc(1007); check("to_pre", 32'(acq_timeout), 0);
      check("to_pre_state", 32'(state), 1);
      cyc(1);   check("to_1025", 32'(acq_timeout), 1);
      check("to_state", 32'(state), 1);
      check("to_unlocked", 32'(locked), 0);

      // Reset mid-window at count 7, then a fresh full-length acquisition
      cyc(7);
      rst_n = 1'b0;
      #1;
      check("mid_rst_to", 32'(acq_timeout), 0);
      check("mid_rst_rail", 32'(alpha_rail), 0);
      check("mid_rst_state", 32'(state), 0);
      @(negedge clk);
      rst_n = 1'b1; hi = 7'd64; lo = 7'd63; tog_mode = 1'b1;
      cyc(32); check("post_rst_pre", 32'(locked), 0);
      check("post_rst_acq", 32'(state), 1);
      cyc(1);  check("post_rst_lock", 32'(locked), 1);
      check("post_rst_sticky", 32'(lol_sticky), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/adpll_lock_monitor.md
ADPLL_LOCK_MONITOR -- requirements
Module: adpll_lock_monitor

Interface
REQ-001 Parameter WIN, default 16: samples per evaluation window (range 4..256).
REQ-002 Parameter TOL, default 2: max allowed alpha spread (max-min) within a good window.
REQ-003 Parameter MIN_TOG, default 4: min lead_lag toggles within a good window.
REQ-004 Parameter GOOD_WINS, default 2: consecutive good windows required to declare lock.
REQ-005 Parameter ACQ_TO, default 64: windows allowed in ACQUIRE before timeout.
REQ-006 clk  in  1  controller reference clock; all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 en  in  1  monitor enable; low forces IDLE.
REQ-009 lead_lag  in  1  phase-detector lead/lag decision, synchronous to clk.
REQ-010 alpha  in  7  DCO control word from the loop controller, synchronous to clk.
REQ-011 clr  in  1  synchronous clear of sticky status and statistics.
REQ-012 locked  out  1  high only in LOCKED state.
REQ-013 lol_pulse  out  1  one-cycle pulse on LOCKED->LOST.
REQ-014 lol_sticky  out  1  set on loss of lock, held until clr.
REQ-015 acq_timeout  out  1  sticky; set when ACQUIRE exceeds ACQ_TO windows.
REQ-016 alpha_rail  out  1  high while last completed window had every alpha sample at 0 or 127.
REQ-017 state  out  2  IDLE=0, ACQUIRE=1, LOCKED=2, LOST=3.
REQ-018 lol_count  out  16  loss-of-lock event count (optional, see Configuration).
REQ-019 alpha_lock  out  7  alpha snapshot at lock entry (optional, see Configuration).

Function
REQ-020 Window counter counts 0..WIN-1 while en=1 and state!=IDLE; wraps to 0; evaluation uses all WIN samples including the sample at count WIN-1.
REQ-021 At count 0, alpha min/max registers load the current sample; otherwise update with it; spread = max-min, unsigned 7-bit.
REQ-022 Toggle counter increments when lead_lag differs from previous-cycle registered lead_lag (reset 0); cleared at window start, saturating at 255.
REQ-023 Good window: spread <= TOL AND toggles >= MIN_TOG AND not railed; railed = every sample in window equals 0 or every sample equals 127.
REQ-024 IDLE -> ACQUIRE on first clk with en=1; window counter starts at 0 that cycle.
REQ-025 ACQUIRE: good window increments good_cnt, bad window clears it; good_cnt reaching GOOD_WINS moves to LOCKED on the edge after the window end.
REQ-026 ACQUIRE: window counter acq_win increments per window; reaching ACQ_TO sets acq_timeout; FSM stays in ACQUIRE.
REQ-027 LOCKED: bad window -> LOST, lol_pulse high exactly one cycle, lol_sticky set; good windows keep LOCKED.
REQ-028 LOST: next good window -> ACQUIRE with good_cnt=1 and acq_win cleared; bad window stays LOST.
REQ-029 en low in any state: next edge -> IDLE, window/toggle/good/acq counters cleared, locked=0; sticky outputs untouched.
REQ-030 clr clears lol_sticky, acq_timeout, lol_count; if a set event occurs the same cycle, set wins.
REQ-031 All status outputs are registered; locked rises the cycle after the final qualifying window sample.

Reset
REQ-032 rst_n low: state=IDLE, all counters 0, min/max 0, locked=0, lol_pulse=0, lol_sticky=0, acq_timeout=0, alpha_rail=0, lol_count=0, alpha_lock=0; reset mid-window discards the partial window.

Configuration
REQ-033 Macro LOCK_MON_STATS_EN defined: lol_count increments on each LOCKED->LOST (saturates at 65535) and alpha_lock captures window midpoint (min+max)>>1 on LOCKED entry.
REQ-034 LOCK_MON_STATS_EN undefined: lol_count and alpha_lock tied to 0, no stats registers synthesized; ports remain.

Verification
REQ-035 Defaults, alpha alternating 63/64, lead_lag toggling every cycle from en rise -> locked=1 at cycle 33, state=2.
REQ-036 Locked, then alpha steps to 70/60 alternating -> lol_pulse one cycle at next window end, lol_sticky=1, state=3, lol_count=1 (stats on).
REQ-037 alpha held 127, lead_lag constant -> alpha_rail=1 after first window, never locks, acq_timeout=1 after 64 windows (cycle 1025).
REQ-038 Locked, en dropped for 1 cycle -> state=0 then 1, locked=0, lol_sticky stays 0.
REQ-039 clr asserted on same cycle as lol_pulse -> lol_sticky=1 afterwards; clr alone next cycle -> lol_sticky=0, lol_count=0.
REQ-040 rst_n pulsed low at window count 7 while ACQUIRE -> all outputs 0 immediately, fresh lock takes full 32 samples after release.
